// File: rtl/lzc_pkg.sv
// Shared constants for the leading-zero / popcount / parity unit.
// Mode encodings and the result-width helper.
package lzc_pkg;

  localparam logic [1:0] LZC_MODE_LZ  = 2'b00;
  localparam logic [1:0] LZC_MODE_POP = 2'b01;
  localparam logic [1:0] LZC_MODE_PAR = 2'b10;
  localparam logic [1:0] LZC_MODE_TZ  = 2'b11;

  function automatic int lzc_rw(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/lzc_group.sv
// Combinational first-level group encoder: non-zero flag,
// leading-zero count, popcount and parity of one GROUP-bit slice.
module lzc_group
  import lzc_pkg::*;
#(
  parameter int GROUP = 8,
  localparam int LZW  = $clog2(GROUP),
  localparam int PW   = $clog2(GROUP) + 1
) (
  input  logic [GROUP-1:0] i_bits,
  output logic             o_nz,
  output logic [LZW-1:0]   o_lz,
  output logic [PW-1:0]    o_pop,
  output logic             o_par
);

  int   lz_cnt;
  int   pop_cnt;
  logic seen;

  always_comb begin
    lz_cnt  = 0;
    pop_cnt = 0;
    seen    = 1'b0;
    for (int i = GROUP - 1; i >= 0; i--) begin
      if (i_bits[i]) begin
        seen = 1'b1;
      end else if (!seen) begin
        lz_cnt = lz_cnt + 1;
      end
      pop_cnt = pop_cnt + int'(i_bits[i]);
    end
    o_nz  = |i_bits;
    // an empty group wraps to count 0; o_nz=0 marks it
    o_lz  = LZW'(lz_cnt);
    o_pop = PW'(pop_cnt);
    o_par = ^i_bits;
  end

endmodule

// File: rtl/lzc_pop_unit.sv
// 3-stage leading-zero / popcount / parity unit with hold and tag.
// Define LZC_TRAILING_ZERO_EN to make mode 11 a trailing-zero count.
module lzc_pop_unit
  import lzc_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int GROUP = 8,
  parameter int TAGW  = 3,
  parameter int RW    = lzc_rw(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  input  logic             i_hold,
  input  logic [1:0]       i_mode,
  input  logic [WIDTH-1:0] i_data,
  input  logic [TAGW-1:0]  i_tag,
  output logic             o_valid,
  output logic [RW-1:0]    o_result,
  output logic [TAGW-1:0]  o_tag,
  output logic             o_zero
);

  localparam int NG  = WIDTH / GROUP;
  localparam int LZW = $clog2(GROUP);
  localparam int PW  = $clog2(GROUP) + 1;

  logic             s1_valid_q, s1_valid_d;
  logic [1:0]       s1_mode_q, s1_mode_d;
  logic [TAGW-1:0]  s1_tag_q, s1_tag_d;
  logic [WIDTH-1:0] s1_data_q, s1_data_d;

  logic             s2_valid_q, s2_valid_d;
  logic [1:0]       s2_mode_q, s2_mode_d;
  logic [TAGW-1:0]  s2_tag_q, s2_tag_d;
  logic [NG-1:0]    s2_nz_q, s2_nz_d;
  logic [NG*LZW-1:0] s2_lz_q, s2_lz_d;
  logic [NG*PW-1:0] s2_pop_q, s2_pop_d;
  logic [NG-1:0]    s2_par_q, s2_par_d;

  logic             out_valid_q, out_valid_d;
  logic [RW-1:0]    out_result_q, out_result_d;
  logic [TAGW-1:0]  out_tag_q, out_tag_d;
  logic             out_zero_q, out_zero_d;

  logic [WIDTH-1:0]  s2_in;
  logic [NG-1:0]     g_nz;
  logic [NG*LZW-1:0] g_lz;
  logic [NG*PW-1:0]  g_pop;
  logic [NG-1:0]     g_par;

  int   lz_sum;
  int   pop_sum;
  logic par_x;
  logic hit;
  logic [RW-1:0] res;

`ifdef LZC_TRAILING_ZERO_EN
  // trailing zeros reuse the LZ encoders on the mirrored operand
  always_comb begin
    s2_in = s1_data_q;
    if (s1_mode_q == LZC_MODE_TZ) begin
      for (int i = 0; i < WIDTH; i++) begin
        s2_in[i] = s1_data_q[WIDTH-1-i];
      end
    end
  end
`else
  assign s2_in = s1_data_q;
`endif

  for (genvar g = 0; g < NG; g++) begin : g_grp
    lzc_group #(
      .GROUP (GROUP)
    ) u_grp (
      .i_bits (s2_in[g*GROUP +: GROUP]),
      .o_nz   (g_nz[g]),
      .o_lz   (g_lz[g*LZW +: LZW]),
      .o_pop  (g_pop[g*PW +: PW]),
      .o_par  (g_par[g])
    );
  end

  always_comb begin
    lz_sum  = 0;
    pop_sum = 0;
    par_x   = 1'b0;
    hit     = 1'b0;
    for (int g = NG - 1; g >= 0; g--) begin
      if (!hit) begin
        if (s2_nz_q[g]) begin
          hit    = 1'b1;
          lz_sum = lz_sum + int'(s2_lz_q[g*LZW +: LZW]);
        end else begin
          lz_sum = lz_sum + GROUP;
        end
      end
      pop_sum = pop_sum + int'(s2_pop_q[g*PW +: PW]);
      par_x   = par_x ^ s2_par_q[g];
    end
    res = '0;
    unique case (s2_mode_q)
      LZC_MODE_LZ:  res = RW'(lz_sum);
      LZC_MODE_POP: res = RW'(pop_sum);
      LZC_MODE_PAR: res = RW'(par_x);
`ifdef LZC_TRAILING_ZERO_EN
      LZC_MODE_TZ:  res = RW'(lz_sum);
`else
      LZC_MODE_TZ:  res = '0;
`endif
    endcase
  end

  // hold freezes every stage; bubbles still advance otherwise
  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_mode_d    = s1_mode_q;
    s1_tag_d     = s1_tag_q;
    s1_data_d    = s1_data_q;
    s2_valid_d   = s2_valid_q;
    s2_mode_d    = s2_mode_q;
    s2_tag_d     = s2_tag_q;
    s2_nz_d      = s2_nz_q;
    s2_lz_d      = s2_lz_q;
    s2_pop_d     = s2_pop_q;
    s2_par_d     = s2_par_q;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_tag_d    = out_tag_q;
    out_zero_d   = out_zero_q;
    if (!i_hold) begin
      s1_valid_d   = i_valid;
      s1_mode_d    = i_mode;
      s1_tag_d     = i_tag;
      s1_data_d    = i_data;
      s2_valid_d   = s1_valid_q;
      s2_mode_d    = s1_mode_q;
      s2_tag_d     = s1_tag_q;
      s2_nz_d      = g_nz;
      s2_lz_d      = g_lz;
      s2_pop_d     = g_pop;
      s2_par_d     = g_par;
      out_valid_d  = s2_valid_q;
      out_result_d = res;
      out_tag_d    = s2_tag_q;
      out_zero_d   = ~|s2_nz_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s1_mode_q    <= '0;
      s1_tag_q     <= '0;
      s1_data_q    <= '0;
      s2_valid_q   <= 1'b0;
      s2_mode_q    <= '0;
      s2_tag_q     <= '0;
      s2_nz_q      <= '0;
      s2_lz_q      <= '0;
      s2_pop_q     <= '0;
      s2_par_q     <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_tag_q    <= '0;
      out_zero_q   <= 1'b0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_mode_q    <= s1_mode_d;
      s1_tag_q     <= s1_tag_d;
      s1_data_q    <= s1_data_d;
      s2_valid_q   <= s2_valid_d;
      s2_mode_q    <= s2_mode_d;
      s2_tag_q     <= s2_tag_d;
      s2_nz_q      <= s2_nz_d;
      s2_lz_q      <= s2_lz_d;
      s2_pop_q     <= s2_pop_d;
      s2_par_q     <= s2_par_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_tag_q    <= out_tag_d;
      out_zero_q   <= out_zero_d;
    end
  end

  assign o_valid  = out_valid_q;
  assign o_result = out_result_q;
  assign o_tag    = out_tag_q;
  assign o_zero   = out_zero_q;

endmodule

// File: tb/tb_lzc_pop_unit.sv
// Scoreboard bench for lzc_pop_unit: 64/8 directed vectors
// plus a 32/4 instance checked against a behavioural model.
module tb_lzc_pop_unit;
  import lzc_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        i_valid = 1'b0;
  logic        i_hold  = 1'b0;
  logic [1:0]  i_mode  = '0;
  logic [63:0] i_data  = '0;
  logic [2:0]  i_tag   = '0;
  logic        o_valid;
  logic [6:0]  o_result;
  logic [2:0]  o_tag;
  logic        o_zero;

  logic        v32 = 1'b0;
  logic        h32 = 1'b0;
  logic [1:0]  m32 = '0;
  logic [31:0] d32 = '0;
  logic [2:0]  t32 = '0;
  logic        ov32;
  logic [5:0]  or32;
  logic [2:0]  ot32;
  logic        oz32;

  lzc_pop_unit #(.WIDTH(64), .GROUP(8), .TAGW(3)) u_dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_hold(i_hold),
    .i_mode(i_mode), .i_data(i_data), .i_tag(i_tag),
    .o_valid(o_valid), .o_result(o_result), .o_tag(o_tag),
    .o_zero(o_zero)
  );

  lzc_pop_unit #(.WIDTH(32), .GROUP(4), .TAGW(3)) u_dut32 (
    .clk(clk), .rst(rst), .i_valid(v32), .i_hold(h32),
    .i_mode(m32), .i_data(d32), .i_tag(t32),
    .o_valid(ov32), .o_result(or32), .o_tag(ot32),
    .o_zero(oz32)
  );

`ifdef LZC_TRAILING_ZERO_EN
  localparam logic [6:0] TZ_100 = 7'd8;
  localparam logic [6:0] TZ_ALL0 = 7'd64;
`else
  localparam logic [6:0] TZ_100 = 7'd0;
  localparam logic [6:0] TZ_ALL0 = 7'd0;
`endif

  typedef struct packed {
    logic [6:0] res;
    logic [2:0] tag;
    logic       zero;
  } exp_t;

  exp_t q64[$];
  exp_t q32[$];
  int   checks = 0;
  int   errors = 0;
  logic upd = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  always @(posedge clk) upd <= !i_hold;

  always @(negedge clk) begin
    exp_t e;
    if (!rst && upd && o_valid) begin
      if (q64.size() == 0) begin
        chk("m64.unexpected_valid", 64'(o_valid), 64'd0);
      end else begin
        e = q64.pop_front();
        chk("m64.result", 64'(o_result), 64'(e.res));
        chk("m64.tag", 64'(o_tag), 64'(e.tag));
        chk("m64.zero", 64'(o_zero), 64'(e.zero));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && ov32) begin
      if (q32.size() == 0) begin
        chk("m32.unexpected_valid", 64'(ov32), 64'd0);
      end else begin
        e = q32.pop_front();
        chk("m32.result", 64'(or32), 64'(e.res));
        chk("m32.tag", 64'(ot32), 64'(e.tag));
        chk("m32.zero", 64'(oz32), 64'(e.zero));
      end
    end
  end

  function automatic exp_t ref32(input logic [1:0] m,
                                 input logic [31:0] d,
                                 input logic [2:0] t);
    int   lz = 32;
    int   tz = 32;
    int   pop = 0;
    exp_t e;
    for (int i = 31; i >= 0; i--) begin
      if (d[i] && lz == 32) lz = 31 - i;
    end
    for (int i = 0; i < 32; i++) begin
      if (d[i] && tz == 32) tz = i;
      pop = pop + int'(d[i]);
    end
    case (m)
      2'b00: e.res = 7'(lz);
      2'b01: e.res = 7'(pop);
      2'b10: e.res = 7'(pop % 2);
`ifdef LZC_TRAILING_ZERO_EN
      default: e.res = 7'(tz);
`else
      default: e.res = 7'd0;
`endif
    endcase
    e.tag  = t;
    e.zero = (d == 32'd0);
    return e;
  endfunction

  task automatic iss(input logic [1:0] m, input logic [63:0] d,
                     input logic [2:0] t, input logic [6:0] r,
                     input logic z);
    exp_t e;
    e = '{res: r, tag: t, zero: z};
    i_valid = 1'b1;
    i_mode  = m;
    i_data  = d;
    i_tag   = t;
    q64.push_back(e);
    @(negedge clk);
    i_valid = 1'b0;
  endtask

  task automatic iss32(input logic [1:0] m, input logic [31:0] d,
                       input logic [2:0] t);
    v32 = 1'b1;
    m32 = m;
    d32 = d;
    t32 = t;
    q32.push_back(ref32(m, d, t));
    @(negedge clk);
    v32 = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 20; k++) begin
      if (q64.size() == 0 && q32.size() == 0) break;
      @(negedge clk);
    end
    chk("drain.pending", 64'(q64.size() + q32.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [10:0] snap;
    int          seen;
    logic [31:0] d;

    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst.valid", 64'(o_valid), 64'd0);
    chk("rst.result", 64'(o_result), 64'd0);
    chk("rst.tag", 64'(o_tag), 64'd0);
    chk("rst.zero", 64'(o_zero), 64'd0);
    chk("rst.valid32", 64'(ov32), 64'd0);

    iss(LZC_MODE_LZ, 64'h0000_0000_0001_0000, 3'd5, 7'd47, 1'b0);
    @(negedge clk);
    chk("lat.edge2_idle", 64'(o_valid), 64'd0);
    @(negedge clk);
    chk("lat.edge3_valid", 64'(o_valid), 64'd1);
    drain();

    iss(LZC_MODE_LZ,  64'h0, 3'd1, 7'd64, 1'b1);
    iss(LZC_MODE_POP, 64'h0, 3'd2, 7'd0, 1'b1);
    iss(LZC_MODE_PAR, 64'h0, 3'd3, 7'd0, 1'b1);
    iss(LZC_MODE_POP, 64'hFFFF_FFFF_FFFF_FFFF, 3'd4, 7'd64, 1'b0);
    iss(LZC_MODE_LZ,  64'hFFFF_FFFF_FFFF_FFFF, 3'd5, 7'd0, 1'b0);
    iss(LZC_MODE_POP, 64'h8000_0000_0000_0003, 3'd6, 7'd3, 1'b0);
    iss(LZC_MODE_PAR, 64'h8000_0000_0000_0003, 3'd7, 7'd1, 1'b0);
    iss(LZC_MODE_POP, 64'h8000_0000_0000_0003, 3'd0, 7'd3, 1'b0);
    iss(LZC_MODE_PAR, 64'h8000_0000_0000_0003, 3'd1, 7'd1, 1'b0);
    iss(LZC_MODE_LZ,  64'h8000_0000_0000_0000, 3'd2, 7'd0, 1'b0);
    iss(LZC_MODE_TZ,  64'h0000_0000_0000_0100, 3'd3, TZ_100, 1'b0);
    iss(LZC_MODE_TZ,  64'h0, 3'd4, TZ_ALL0, 1'b1);
    iss(LZC_MODE_LZ,  64'h0000_0000_0000_00FF, 3'd5, 7'd56, 1'b0);
    drain();

    iss(LZC_MODE_LZ,  64'h0000_0000_0000_00FF, 3'd1, 7'd56, 1'b0);
    iss(LZC_MODE_POP, 64'h0000_0000_0000_00FF, 3'd2, 7'd8, 1'b0);
    iss(LZC_MODE_PAR, 64'h0000_0000_0000_0007, 3'd3, 7'd1, 1'b0);
    i_hold = 1'b1;
    snap = {o_valid, o_result, o_tag};
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("hold.frozen", 64'({o_valid, o_result, o_tag}), 64'(snap));
    end
    i_hold = 1'b0;
    drain();

    iss(LZC_MODE_POP, 64'hFFFF_FFFF_FFFF_FFFF, 3'd4, 7'd64, 1'b0);
    iss(LZC_MODE_LZ,  64'h0, 3'd5, 7'd64, 1'b1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    q64.delete();
    #1;
    chk("arst.valid_drop", 64'(o_valid), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (o_valid) seen++;
    end
    chk("arst.no_ghost", 64'(seen), 64'd0);
    iss(LZC_MODE_LZ, 64'h0000_0000_0001_0000, 3'd6, 7'd47, 1'b0);
    drain();

    iss32(2'b00, 32'h0, 3'd1);
    iss32(2'b11, 32'h0000_0100, 3'd2);
    for (int k = 0; k < 24; k++) begin
      d = $urandom >> $urandom_range(0, 31);
      if (k % 7 == 0) d = 32'h0;
      iss32(2'($urandom_range(0, 3)), d, 3'(k));
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
